// File: rtl/segmenter.sv
// -----------------------------------------------------------------------------
// segmenter
//
// Registered hexadecimal-to-seven-segment decoder for one HEX display digit.
// Adds lamp-test and blanking overrides to the nibble decode. An optional
// blink function is compiled in when the macro SEGMENTER_BLINK_EN is defined.
// Without it, the blink input is ignored and no counter or phase logic exists.
//
// Parameters
//   ACTIVE_LOW : 1 = a segment is lit by driving 0 (common anode), 0 = lit by 1
//   BLINK_DIV  : clock cycles per blink half-period (1 .. 2^32-1)
//
// Ports
//   clock     in   single clock, rising edge
//   reset     in   asynchronous, active-high; forces the output dark
//   value     in   [3:0] nibble to display
//   blank     in   1 = all segments dark
//   lamp_test in   1 = all segments lit (highest priority)
//   blink     in   1 = flash the digit (only with SEGMENTER_BLINK_EN)
//   seg_out   out  [6:0] registered segment drive, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module segmenter #(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter logic [31:0] BLINK_DIV  = 32'd25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] value,
    input  logic       blank,
    input  logic       lamp_test,
    input  logic       blink,
    output logic [6:0] seg_out
);

    // Drive levels in the board's polarity.
    localparam logic [6:0] SEG_ALL_LIT  = ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [6:0] SEG_ALL_DARK = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] pattern;      // active-high gfedcba decode of value
    logic [6:0] seg_d;
    logic [6:0] seg_q;
    logic       blink_dark;   // 1 while the blink function hides the digit

`ifdef SEGMENTER_BLINK_EN
    logic [31:0] cnt_d;
    logic [31:0] cnt_q;
    logic        phase_d;
    logic        phase_q;

    // Free-running half-period counter; the phase flips on each wrap so the
    // digit spends BLINK_DIV cycles visible, then BLINK_DIV cycles dark.
    always_comb begin
        cnt_d   = cnt_q + 32'd1;
        phase_d = phase_q;
        if (cnt_q >= BLINK_DIV - 32'd1) begin
            cnt_d   = 32'd0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= 32'd0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_dark = blink & phase_q;
`else
    // Blink is a no-op in this build; the port stays for a uniform interface.
    logic unused_blink;
    assign unused_blink = blink;
    assign blink_dark   = 1'b0;
`endif

    always_comb begin
        pattern = 7'h00;
        unique case (value)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            4'hF: pattern = 7'h71;
            default: pattern = 7'h00;
        endcase
    end

    // Override priority: lamp test, then blank, then blink-dark, then decode.
    always_comb begin
        seg_d = ACTIVE_LOW ? ~pattern : pattern;
        if (lamp_test) begin
            seg_d = SEG_ALL_LIT;
        end else if (blank || blink_dark) begin
            seg_d = SEG_ALL_DARK;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_ALL_DARK;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_out = seg_q;

endmodule

// File: tb/tb_segmenter.sv
// -----------------------------------------------------------------------------
// tb_segmenter
//
// Drives one active-low and one active-high segmenter from the same stimulus.
// Each issued stimulus pushes the expected output of both instances into a
// scoreboard queue; a monitor pops and compares one entry per clock edge.
// Reset behaviour is checked directly at the moment reset is asserted.
// -----------------------------------------------------------------------------
module tb_segmenter;

    localparam logic [31:0] DIV = 32'd4;

`ifdef SEGMENTER_BLINK_EN
    localparam bit BLINK_BUILD = 1'b1;
`else
    localparam bit BLINK_BUILD = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [3:0] value;
    logic       blank;
    logic       lamp_test;
    logic       blink;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;

    int checks   = 0;
    int failures = 0;

    // Expected values, one entry per sampled edge: {active-low, active-high}.
    logic [13:0] exp_q[$];
    int          k;   // edges sampled since the last reset release

    segmenter #(.ACTIVE_LOW(1'b1), .BLINK_DIV(DIV)) dut_lo (
        .clock(clock), .reset(reset), .value(value), .blank(blank),
        .lamp_test(lamp_test), .blink(blink), .seg_out(seg_lo)
    );

    segmenter #(.ACTIVE_LOW(1'b0), .BLINK_DIV(DIV)) dut_hi (
        .clock(clock), .reset(reset), .value(value), .blank(blank),
        .lamp_test(lamp_test), .blink(blink), .seg_out(seg_hi)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: lit-segment sets from the digit table, with the override
    // priority and the blink phase derived from the edge count since reset.
    function automatic logic [6:0] model(input logic [3:0] v, input logic b,
                                         input logic l, input logic bk,
                                         input int kk, input bit active_low);
        logic [6:0] lit_tab [16];
        logic [6:0] lit;
        lit_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        if (l)
            lit = 7'h7F;
        else if (b)
            lit = 7'h00;
        else if (BLINK_BUILD && bk && (((kk / int'(DIV)) % 2) == 1))
            lit = 7'h00;
        else
            lit = lit_tab[v];
        return active_low ? ~lit : lit;
    endfunction

    function automatic void check(input string name, input logic [6:0] act,
                                  input logic [6:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endfunction

    // Monitor: one output per edge, compared against the scoreboard.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                logic [13:0] e;
                e = exp_q.pop_front();
                check("seg_lo", seg_lo, e[13:7]);
                check("seg_hi", seg_hi, e[6:0]);
                $display("edge k=%0d lo=%02h hi=%02h", k, seg_lo, seg_hi);
            end
        end
    end

    // Drive one combination ahead of the next edge and record its expectation.
    task automatic step(input logic [3:0] v, input logic b, input logic l,
                        input logic bk);
        @(posedge clock);
        #2;
        reset     = 1'b0;
        value     = v;
        blank     = b;
        lamp_test = l;
        blink     = bk;
        exp_q.push_back({model(v, b, l, bk, k, 1'b1), model(v, b, l, bk, k, 1'b0)});
        k++;
    endtask

    // Assert reset between edges and check the output goes dark at once.
    task automatic do_reset();
        @(posedge clock);
        #3;
        reset = 1'b1;
        exp_q.delete();
        k = 0;
        #1;
        check("reset_lo", seg_lo, 7'h7F);
        check("reset_hi", seg_hi, 7'h00);
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold_lo", seg_lo, 7'h7F);
        check("reset_hold_hi", seg_hi, 7'h00);
    endtask

    initial begin
        reset     = 1'b0;
        value     = 4'h0;
        blank     = 1'b0;
        lamp_test = 1'b0;
        blink     = 1'b0;
        k         = 0;

        // Reset before any clock edge.
        #1;
        reset = 1'b1;
        #1;
        check("por_lo", seg_lo, 7'h7F);
        check("por_hi", seg_hi, 7'h00);

        // Decode sweep.
        for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0, 1'b0);

        // Priority.
        step(4'h5, 1'b1, 1'b0, 1'b0);
        step(4'h5, 1'b1, 1'b1, 1'b0);
        step(4'h5, 1'b0, 1'b0, 1'b0);
        step(4'hA, 1'b0, 1'b1, 1'b1);

        // Blink phases: a fresh reset so the phase starts visible.
        do_reset();
        for (int i = 0; i < 12; i++) step(4'h3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'h3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(4'h3, 1'b0, 1'b0, 1'b1);

        // Reset mid-sequence.
        do_reset();
        for (int i = 0; i < 10; i++) step(4'h3, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
            if (i == 97) do_reset();
        end

        // Drain the scoreboard.
        repeat (3) @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
